pc_ir_unit: RTL and testbench

// Multicycle MIPS fetch/state-register stage that feeds maindec and consumes its strobes.

---
 rtl/pc_ir_unit.sv | 102 ++++++++++
 tb/tb_pc_ir_unit.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/pc_ir_unit.sv
// Multicycle MIPS fetch stage: holds the PC, IR, MDR and ALUOut registers.
// It also selects the memory address, computes the next PC and slices IR fields for the decoder.
module pc_ir_unit #(
  parameter int unsigned     WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pcwrite,
  input  logic             branch,
  input  logic             IorD,
  input  logic             IRwrite,
  input  logic [1:0]       pcsrc,
  input  logic [WIDTH-1:0] aluresult,
  input  logic             zero,
  input  logic [WIDTH-1:0] readdata,
  output logic [WIDTH-1:0] adr,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] instr,
  output logic [5:0]       op,
  output logic [5:0]       funct,
  output logic [4:0]       rs,
  output logic [4:0]       rt,
  output logic [4:0]       rd,
  output logic [15:0]      imm,
  output logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] aluout,
  output logic             adr_misaligned
);

  localparam logic [1:0] PcSrcAlu    = 2'b00;
  localparam logic [1:0] PcSrcAluOut = 2'b01;
  localparam logic [1:0] PcSrcJump   = 2'b10;
  localparam logic [1:0] PcSrcHold   = 2'b11;

  logic [WIDTH-1:0] r_pc;
  logic [WIDTH-1:0] r_instr;
  logic [WIDTH-1:0] r_data;
  logic [WIDTH-1:0] r_aluout;

  logic             w_pcen;
  logic [WIDTH-1:0] w_pc_next;
  logic [WIDTH-1:0] w_jump_target;

  assign w_pcen = pcwrite | (branch & zero);

  // Upper PC bits above the 28-bit jump region are kept from the current PC.
  assign w_jump_target = {r_pc[WIDTH-1:28], r_instr[25:0], 2'b00};

  always_comb begin
    w_pc_next = r_pc;
    unique case (pcsrc)
      PcSrcAlu:    w_pc_next = aluresult;
      PcSrcAluOut: w_pc_next = r_aluout;
      PcSrcJump:   w_pc_next = w_jump_target;
      PcSrcHold:   w_pc_next = r_pc;
      default:     w_pc_next = r_pc;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc <= RESET_PC;
    end else if (w_pcen) begin
      r_pc <= w_pc_next;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_instr <= '0;
    end else if (IRwrite) begin
      r_instr <= readdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_data   <= '0;
      r_aluout <= '0;
    end else begin
      r_data   <= readdata;
      r_aluout <= aluresult;
    end
  end

  assign adr            = IorD ? r_aluout : r_pc;
  assign adr_misaligned = |adr[1:0];

  assign pc     = r_pc;
  assign instr  = r_instr;
  assign data   = r_data;
  assign aluout = r_aluout;

  assign op    = r_instr[31:26];
  assign rs    = r_instr[25:21];
  assign rt    = r_instr[20:16];
  assign rd    = r_instr[15:11];
  assign imm   = r_instr[15:0];
  assign funct = r_instr[5:0];

endmodule

// File: tb/tb_pc_ir_unit.sv
// Directed bench for pc_ir_unit: reset, fetch, branch, jump, load-data and address-select steps.
// Each expected value below is worked out by hand from the instruction encodings and register contents.
module tb_pc_ir_unit;

  logic        clk;
  logic        reset;
  logic        pcwrite;
  logic        branch;
  logic        IorD;
  logic        IRwrite;
  logic [1:0]  pcsrc;
  logic [31:0] aluresult;
  logic        zero;
  logic [31:0] readdata;
  logic [31:0] adr;
  logic [31:0] pc;
  logic [31:0] instr;
  logic [5:0]  op;
  logic [5:0]  funct;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [15:0] imm;
  logic [31:0] data;
  logic [31:0] aluout;
  logic        adr_misaligned;

  int n_cmp;
  int n_fail;

  pc_ir_unit #(
    .WIDTH   (32),
    .RESET_PC(32'h0)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .pcwrite       (pcwrite),
    .branch        (branch),
    .IorD          (IorD),
    .IRwrite       (IRwrite),
    .pcsrc         (pcsrc),
    .aluresult     (aluresult),
    .zero          (zero),
    .readdata      (readdata),
    .adr           (adr),
    .pc            (pc),
    .instr         (instr),
    .op            (op),
    .funct         (funct),
    .rs            (rs),
    .rt            (rt),
    .rd            (rd),
    .imm           (imm),
    .data          (data),
    .aluout        (aluout),
    .adr_misaligned(adr_misaligned)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge; sampling happens 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp     = 0;
    n_fail    = 0;
    reset     = 1'b1;
    pcwrite   = 1'b0;
    branch    = 1'b0;
    IorD      = 1'b0;
    IRwrite   = 1'b0;
    pcsrc     = 2'b00;
    aluresult = 32'h0;
    zero      = 1'b0;
    readdata  = 32'h0;

    tick();
    tick();
    check("rst_pc", pc, 32'h0);
    check("rst_instr", instr, 32'h0);
    check("rst_data", data, 32'h0);
    check("rst_aluout", aluout, 32'h0);
    reset = 1'b0;

    // Bring PC to 0x40 with a non-zero IR, then reset between edges.
    pcwrite   = 1'b1;
    IRwrite   = 1'b1;
    aluresult = 32'h40;
    readdata  = 32'h8C08_0004;
    tick();
    check("pre_pc", pc, 32'h40);
    check("pre_op", {26'h0, op}, 32'h23);
    reset = 1'b1;
    #1;
    check("async_pc", pc, 32'h0);
    check("async_instr", instr, 32'h0);
    check("async_op", {26'h0, op}, 32'h0);
    check("async_aluout", aluout, 32'h0);
    pcwrite   = 1'b0;
    IRwrite   = 1'b0;
    aluresult = 32'h0;
    readdata  = 32'h0;
    #1;
    reset = 1'b0;
    tick();
    check("post_rst_pc", pc, 32'h0);

    // Fetch lw $t0, 4($zero).
    IorD      = 1'b0;
    readdata  = 32'h8C08_0004;
    IRwrite   = 1'b1;
    pcwrite   = 1'b1;
    pcsrc     = 2'b00;
    aluresult = 32'h4;
    #1;
    check("fetch_adr", adr, 32'h0);
    tick();
    check("fetch_instr", instr, 32'h8C08_0004);
    check("fetch_op", {26'h0, op}, 32'h23);
    check("fetch_rs", {27'h0, rs}, 32'h0);
    check("fetch_rt", {27'h0, rt}, 32'h8);
    check("fetch_imm", {16'h0, imm}, 32'h4);
    check("fetch_pc", pc, 32'h4);
    check("fetch_aluout", aluout, 32'h4);
    check("fetch_data", data, 32'h8C08_0004);

    // Branch: ALUOut = 0x20, then beq taken.
    IRwrite   = 1'b0;
    pcwrite   = 1'b0;
    aluresult = 32'h20;
    readdata  = 32'h0;
    tick();
    check("beq_setup_pc", pc, 32'h4);
    check("beq_setup_aluout", aluout, 32'h20);
    branch = 1'b1;
    pcsrc  = 2'b01;
    zero   = 1'b1;
    tick();
    check("beq_taken_pc", pc, 32'h20);
    zero      = 1'b0;
    aluresult = 32'h80;
    tick();
    check("beq_not_taken_pc", pc, 32'h20);
    check("beq_nt_aluout", aluout, 32'h80);
    pcwrite = 1'b1;
    tick();
    check("pcwrite_override_pc", pc, 32'h80);
    check("ir_held", instr, 32'h8C08_0004);

    // Jump: fetch j 0x10 at pc 0x10000004 then take the jump.
    branch    = 1'b0;
    pcsrc     = 2'b00;
    aluresult = 32'h1000_0004;
    IRwrite   = 1'b1;
    readdata  = 32'h0800_0010;
    tick();
    check("j_fetch_pc", pc, 32'h1000_0004);
    check("j_fetch_op", {26'h0, op}, 32'h2);
    IRwrite = 1'b0;
    pcsrc   = 2'b10;
    tick();
    check("jump_pc", pc, 32'h1000_0040);

    // lw data phase.
    pcwrite   = 1'b0;
    pcsrc     = 2'b00;
    aluresult = 32'h100;
    readdata  = 32'h0;
    tick();
    IorD = 1'b1;
    #1;
    check("lw_adr", adr, 32'h100);
    check("lw_aligned", {31'h0, adr_misaligned}, 32'h0);
    readdata = 32'hDEAD_BEEF;
    tick();
    check("lw_data", data, 32'hDEAD_BEEF);
    check("lw_ir_held", instr, 32'h0800_0010);
    check("lw_pc_held", pc, 32'h1000_0040);

    // Misaligned address and pcsrc=11 hold.
    aluresult = 32'h102;
    tick();
    check("mis_adr", adr, 32'h102);
    check("mis_flag", {31'h0, adr_misaligned}, 32'h1);
    pcwrite = 1'b1;
    pcsrc   = 2'b11;
    tick();
    check("hold_pc", pc, 32'h1000_0040);
    IorD = 1'b0;
    #1;
    check("pc_adr", adr, 32'h1000_0040);
    check("pc_adr_aligned", {31'h0, adr_misaligned}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
